sprite_clut_ram: RTL and testbench
==================================

Name: sprite_clut_ram

Overview:
- Runtime-writable, multi-bank colour look-up table for sprite rendering; maps a sprite pixel index plus palette-bank select to RGB for the VGA colour mapper.
- Generalises the fixed 16-entry per-sprite ROM palettes: parametrised depth, colour width and bank count, with a write port, an init sequencer, transparency detection and a registered 2-cycle read pipeline.

Parameters:
- INDEX_W, 4, pixel-index width; depth per bank = 2**INDEX_W.
- COLOR_W, 4, bits per colour channel.
- NUM_BANKS, 4, number of palettes (>=2); localparam BANK_W = $clog2(NUM_BANKS).
- TRANSP_INDEX, 0, index reported as transparent (colour key).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_bank  in  BANK_W  bank to write.
- wr_index  in  INDEX_W  entry to write.
- wr_rgb  in  3*COLOR_W  {R,G,B} data.
- rd_valid  in  1  read request; no backpressure.
- rd_bank  in  BANK_W  bank to read.
- rd_index  in  INDEX_W  entry to read.
- out_valid  out  1  red/green/blue/transparent valid.
- red, green, blue  out  COLOR_W each  looked-up colour.
- transparent  out  1  high when the read index == TRANSP_INDEX.
- init_done  out  1  high once the table is loaded.

Behaviour:
- Reset is synchronous and active-high on Clk, and has priority over all other inputs. It applies in any cycle, including mid-init and mid-pipeline.
- Reset values: wr_ready=0, out_valid=0, red/green/blue=0, transparent=0, init_done=0, FSM=INIT, init counter=0.
- FSM states:
  - INIT: writes one entry per cycle; entry (b,i) = DEFAULT_PAL[i mod 16], with COLOR_W-bit channels taken from the low bits or zero-extended. Runs for NUM_BANKS*2**INDEX_W cycles, then goes to IDLE.
  - IDLE: terminal until the next Reset.
- init_done and wr_ready go high on the first cycle in IDLE; both stay 0 throughout INIT.
- During INIT, rd_valid is ignored: no pipeline entry and out_valid stays 0.
- Write: accepted in IDLE when wr_valid && wr_ready; the table updates at that clock edge. wr_ready is constantly 1 in IDLE.
- Read pipeline, latency exactly 2:
  - rd_valid sampled at edge t produces out_valid=1 at edge t+2 with that entry's colour.
  - Stage 1 is the synchronous memory read; stage 2 registers the outputs.
  - Fully pipelined: one read per cycle; back-to-back reads give back-to-back out_valid.
- When out_valid=0, red/green/blue/transparent hold their last values.
- Same-cycle write and read to the same (bank,index) is read-first: the read returns old data. A read issued one cycle later returns the new data.
- transparent = (rd_index == TRANSP_INDEX), pipelined alongside the colour. It is independent of bank and of the stored colour.
- Index and bank are used as unsigned values with no wrap logic needed. wr_bank/rd_bank >= NUM_BANKS (possible only when NUM_BANKS is not a power of 2): writes are dropped and reads return 0 with transparent computed normally.

Optional Feature:
- Macro: SPRITE_CLUT_FADE_EN.
- Defined:
  - Adds input port fade [3:0], sampled with rd_valid and pipelined with the request.
  - Each output channel = (c * (fade+1)) >> 4, computed in stage 2 with no latency change.
  - fade=15 is identity; fade=0 gives c>>4, i.e. 0 for COLOR_W=4.
- Undefined: no fade port; outputs are the raw table contents.

Decomposition:
- Package sprite_clut_pkg holds:
  - DEFAULT_PAL, 16 x 12-bit, entries 0..15 = F0D,000,EB9,444,76C,944,FFF,521,492,605,D65,C96,211,548,277,A09;
  - the state enum clut_state_t {INIT, IDLE};
  - the fade helper function.
- One natural sub-module: sprite_clut_bank_mem, a simple dual-port synchronous RAM (1W/1R, read-first) of NUM_BANKS*2**INDEX_W words of 3*COLOR_W bits.

Test Plan:
- Reset, then count cycles -> init_done rises exactly 64 cycles after Reset deasserts (defaults); wr_ready=0 and out_valid=0 throughout.
- After init, read bank 2 index 2 at cycle t -> out_valid at t+2 with {E,B,9}, transparent=0; read index 0 -> {F,0,D}, transparent=1.
- Write bank 1 index 6 = 3A5, and read bank 1 index 6 in the same cycle -> FFF. A read one cycle later -> 3A5; bank 0 index 6 is still FFF.
- 16 consecutive reads of indices 0..15 -> 16 consecutive out_valid cycles, matching DEFAULT_PAL in order.
- Assert Reset mid-stream with reads in flight -> out_valid=0 next cycle, init reruns, and the earlier write of 3A5 is gone (FFF again).
- With SPRITE_CLUT_FADE_EN, fade=7, read entry FFF -> {7,7,7}; fade=15 -> {F,F,F}.

Source files
------------

// File: rtl/sprite_clut_pkg.sv
// +-----------------------------------------------------------------------------+
// | sprite_clut_pkg : shared types, default palette and fade helper             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package sprite_clut_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    IDLE = 1'b1
  } clut_state_t;

  // 12-bit {R,G,B} nibbles loaded into every bank at init
  localparam logic [11:0] DEFAULT_PAL [16] = '{
    12'hF0D, 12'h000, 12'hEB9, 12'h444, 12'h76C, 12'h944, 12'hFFF, 12'h521,
    12'h492, 12'h605, 12'hD65, 12'hC96, 12'h211, 12'h548, 12'h277, 12'hA09
  };

  function automatic logic [15:0] fade_scale(input logic [15:0] c, input logic [3:0] f);
    logic [19:0] p;
    p = {4'd0, c} * {15'd0, ({1'b0, f} + 5'd1)};
    return 16'(p >> 4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_clut_ram_if.sv
// +-----------------------------------------------------------------------------+
// | sprite_clut_if : write/read/result bus of the sprite CLUT                   |
// | Optional macro: SPRITE_CLUT_FADE_EN adds the fade input.  Revision: 1.0     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface sprite_clut_if #(
  parameter int INDEX_W   = 4,
  parameter int COLOR_W   = 4,
  parameter int NUM_BANKS = 4
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  logic                 wr_valid;
  logic                 wr_ready;
  logic [BANK_W-1:0]    wr_bank;
  logic [INDEX_W-1:0]   wr_index;
  logic [3*COLOR_W-1:0] wr_rgb;
  logic                 rd_valid;
  logic [BANK_W-1:0]    rd_bank;
  logic [INDEX_W-1:0]   rd_index;
  logic                 out_valid;
  logic [COLOR_W-1:0]   red;
  logic [COLOR_W-1:0]   green;
  logic [COLOR_W-1:0]   blue;
  logic                 transparent;
  logic                 init_done;
`ifdef SPRITE_CLUT_FADE_EN
  logic [3:0]           fade;
`endif

  modport master (
    output wr_valid, wr_bank, wr_index, wr_rgb, rd_valid, rd_bank, rd_index,
`ifdef SPRITE_CLUT_FADE_EN
    output fade,
`endif
    input  wr_ready, out_valid, red, green, blue, transparent, init_done
  );

  modport slave (
    input  wr_valid, wr_bank, wr_index, wr_rgb, rd_valid, rd_bank, rd_index,
`ifdef SPRITE_CLUT_FADE_EN
    input  fade,
`endif
    output wr_ready, out_valid, red, green, blue, transparent, init_done
  );

endinterface

`default_nettype wire

// File: rtl/sprite_clut_ram_bank_mem.sv
// +-----------------------------------------------------------------------------+
// | sprite_clut_bank_mem : 1W/1R synchronous RAM, read-first on collision       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sprite_clut_bank_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 12
) (
  input  wire logic          clk,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [DW-1:0] i_wdata,
  input  wire logic          i_re,
  input  wire logic [AW-1:0] i_raddr,
  output logic      [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

`default_nettype wire

// File: rtl/sprite_clut_ram.sv
// +-----------------------------------------------------------------------------+
// | sprite_clut_ram : multi-bank runtime-writable sprite colour look-up table   |
// | Optional macro: SPRITE_CLUT_FADE_EN (per-read brightness fade).  Rev: 1.0   |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sprite_clut_ram
  import sprite_clut_pkg::*;
#(
  parameter int INDEX_W      = 4,
  parameter int COLOR_W      = 4,
  parameter int NUM_BANKS    = 4,
  parameter int TRANSP_INDEX = 0
) (
  input wire logic    Clk,
  input wire logic    Reset,
  sprite_clut_if.slave bus
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int AW     = BANK_W + INDEX_W;
  localparam int DEPTH  = NUM_BANKS * (2 ** INDEX_W);
  localparam int DW     = 3 * COLOR_W;
  localparam logic [AW-1:0]      c_LAST   = AW'(DEPTH - 1);
  localparam logic [INDEX_W-1:0] c_TRANSP = INDEX_W'(TRANSP_INDEX);

  clut_state_t        r_state, w_state_nxt;
  logic [AW-1:0]      r_cnt, w_cnt_nxt;
  logic               w_init_we, w_idle, w_wr_inrange, w_rd_inrange, w_rd_fire, w_wr_fire;
  logic [3:0]         w_pal_sel;
  logic [11:0]        w_pal;
  logic [DW-1:0]      w_init_rgb, w_mem_wdata, w_mem_rdata, w_rgb;
  logic [AW-1:0]      w_mem_waddr, w_mem_raddr;
  logic               w_mem_we;
  logic               r_s1_valid, r_s1_transp, r_s1_oob;
  logic [COLOR_W-1:0] w_out_ch [3];
  logic [COLOR_W-1:0] r_red, r_green, r_blue;
  logic               r_out_valid, r_transp;
`ifdef SPRITE_CLUT_FADE_EN
  logic [3:0]         r_s1_fade;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The init counter doubles as the flat {bank,index} write address
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_init_we   = 1'b0;
    case (r_state)
      INIT: begin
        w_init_we = 1'b1;
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == c_LAST) w_state_nxt = IDLE;
      end
      IDLE:    w_state_nxt = IDLE;
      default: w_state_nxt = INIT;
    endcase
  end

  assign w_idle        = (r_state == IDLE);
  assign bus.init_done = w_idle;
  assign bus.wr_ready  = w_idle;

  generate
    if (2 ** BANK_W == NUM_BANKS) begin : g_pow2_banks
      assign w_wr_inrange = 1'b1;
      assign w_rd_inrange = 1'b1;
    end else begin : g_npow2_banks
      assign w_wr_inrange = (32'(bus.wr_bank) < NUM_BANKS);
      assign w_rd_inrange = (32'(bus.rd_bank) < NUM_BANKS);
    end

    if (INDEX_W >= 4) begin : g_sel_wide
      assign w_pal_sel = r_cnt[3:0];
    end else begin : g_sel_narrow
      assign w_pal_sel = 4'(r_cnt[INDEX_W-1:0]);
    end
  endgenerate

  assign w_pal = DEFAULT_PAL[w_pal_sel];

  // Each 4-bit palette nibble is zero-extended or truncated to COLOR_W
  generate
    for (genvar ch = 0; ch < 3; ch++) begin : g_init_ch
      if (COLOR_W >= 4) begin : g_ext
        assign w_init_rgb[COLOR_W*ch +: COLOR_W] = COLOR_W'(w_pal[4*ch +: 4]);
      end else begin : g_trunc
        assign w_init_rgb[COLOR_W*ch +: COLOR_W] = w_pal[4*ch +: COLOR_W];
      end
    end
  endgenerate

  assign w_rd_fire   = bus.rd_valid & w_idle;
  assign w_wr_fire   = bus.wr_valid & w_idle & w_wr_inrange;
  assign w_mem_we    = w_init_we | w_wr_fire;
  assign w_mem_waddr = w_init_we ? r_cnt : {bus.wr_bank, bus.wr_index};
  assign w_mem_wdata = w_init_we ? w_init_rgb : bus.wr_rgb;
  assign w_mem_raddr = w_rd_inrange ? {bus.rd_bank, bus.rd_index} : '0;

  sprite_clut_bank_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_mem (
    .clk     (Clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_re    (w_rd_fire),
    .i_raddr (w_mem_raddr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_transp <= 1'b0;
      r_s1_oob    <= 1'b0;
`ifdef SPRITE_CLUT_FADE_EN
      r_s1_fade   <= 4'd0;
`endif
    end else begin
      r_s1_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_s1_transp <= (bus.rd_index == c_TRANSP);
        r_s1_oob    <= ~w_rd_inrange;
`ifdef SPRITE_CLUT_FADE_EN
        r_s1_fade   <= bus.fade;
`endif
      end
    end
  end

  assign w_rgb = r_s1_oob ? '0 : w_mem_rdata;

  generate
    for (genvar ch = 0; ch < 3; ch++) begin : g_out_ch
`ifdef SPRITE_CLUT_FADE_EN
      assign w_out_ch[ch] = COLOR_W'(fade_scale(16'(w_rgb[COLOR_W*ch +: COLOR_W]), r_s1_fade));
`else
      assign w_out_ch[ch] = w_rgb[COLOR_W*ch +: COLOR_W];
`endif
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_transp    <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_red    <= w_out_ch[2];
        r_green  <= w_out_ch[1];
        r_blue   <= w_out_ch[0];
        r_transp <= r_s1_transp;
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.red         = r_red;
  assign bus.green       = r_green;
  assign bus.blue        = r_blue;
  assign bus.transparent = r_transp;

endmodule

`default_nettype wire

// File: tb/tb_sprite_clut_ram.sv
// +-----------------------------------------------------------------------------+
// | tb_sprite_clut_ram : randomized bench with an array-based palette model     |
// | Honours SPRITE_CLUT_FADE_EN.  Revision: 1.0                                 |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_sprite_clut_ram;

  localparam int c_BANKS = 4;
  localparam int c_ENTR  = 16;
  localparam int c_INIT_CYCLES = c_BANKS * c_ENTR;

  typedef struct {
    logic        v;
    logic [11:0] rgb;
    logic        t;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_errors = 0;

  int          cnt;
  logic [11:0] model [c_BANKS][c_ENTR];
  logic [11:0] last_rgb;
  logic        last_t;
  exp_t        q[$];

  sprite_clut_if #(.INDEX_W(4), .COLOR_W(4), .NUM_BANKS(4)) bus ();

  sprite_clut_ram #(
    .INDEX_W      (4),
    .COLOR_W      (4),
    .NUM_BANKS    (4),
    .TRANSP_INDEX (0)
  ) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    logic [11:0] pal [16];
    pal = '{12'hF0D, 12'h000, 12'hEB9, 12'h444, 12'h76C, 12'h944, 12'hFFF, 12'h521,
            12'h492, 12'h605, 12'hD65, 12'hC96, 12'h211, 12'h548, 12'h277, 12'hA09};
    for (int b = 0; b < c_BANKS; b++)
      for (int i = 0; i < c_ENTR; i++)
        model[b][i] = pal[i];
  endtask

  function automatic logic [11:0] scale(input logic [11:0] c, input int f);
    logic [11:0] r;
    for (int k = 0; k < 3; k++)
      r[4*k +: 4] = 4'((int'(c[4*k +: 4]) * (f + 1)) >> 4);
    return r;
  endfunction

  task automatic tick();
    exp_t e;
    int   f;
    if (Reset) begin
      q.delete();
      reset_model();
      cnt = 0;
      @(posedge Clk); #1;
      last_rgb = 12'h000;
      last_t   = 1'b0;
      check_val("rst_out_valid", bus.out_valid, 0);
      check_val("rst_rgb", {bus.red, bus.green, bus.blue}, 0);
      check_val("rst_transp", bus.transparent, 0);
      check_val("rst_init_done", bus.init_done, 0);
      check_val("rst_wr_ready", bus.wr_ready, 0);
    end else begin
      f = 15;
`ifdef SPRITE_CLUT_FADE_EN
      f = int'(bus.fade);
`endif
      e.v   = bus.rd_valid && (cnt >= c_INIT_CYCLES);
      e.rgb = scale(model[bus.rd_bank][bus.rd_index], f);
      e.t   = (bus.rd_index == 0);
      q.push_back(e);
      if (bus.wr_valid && cnt >= c_INIT_CYCLES)
        model[bus.wr_bank][bus.wr_index] = bus.wr_rgb;
      if (cnt < c_INIT_CYCLES) cnt++;
      @(posedge Clk); #1;
      check_val("init_done", bus.init_done, cnt >= c_INIT_CYCLES);
      check_val("wr_ready", bus.wr_ready, cnt >= c_INIT_CYCLES);
      if (q.size() == 2) begin
        e = q.pop_front();
        if (e.v) begin
          last_rgb = e.rgb;
          last_t   = e.t;
        end
        check_val("out_valid", bus.out_valid, e.v);
      end else begin
        check_val("out_valid_fill", bus.out_valid, 0);
      end
      check_val("rgb", {bus.red, bus.green, bus.blue}, last_rgb);
      check_val("transparent", bus.transparent, last_t);
    end
  endtask

  task automatic drive_idle();
    bus.rd_valid = 1'b0;
    bus.wr_valid = 1'b0;
  endtask

  task automatic drive_rd(input int b, input int i);
    bus.rd_valid = 1'b1;
    bus.rd_bank  = 2'(b);
    bus.rd_index = 4'(i);
  endtask

  task automatic drive_wr(input int b, input int i, input logic [11:0] rgb);
    bus.wr_valid = 1'b1;
    bus.wr_bank  = 2'(b);
    bus.wr_index = 4'(i);
    bus.wr_rgb   = rgb;
  endtask

  task automatic random_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      bus.rd_valid = ($urandom_range(0, 3) != 0);
      bus.rd_bank  = 2'($urandom_range(0, 3));
      bus.rd_index = 4'($urandom_range(0, 15));
      bus.wr_valid = ($urandom_range(0, 2) == 0);
      bus.wr_bank  = 2'($urandom_range(0, 3));
      bus.wr_index = 4'($urandom_range(0, 15));
      bus.wr_rgb   = 12'($urandom);
`ifdef SPRITE_CLUT_FADE_EN
      bus.fade     = 4'($urandom_range(0, 15));
`endif
      tick();
    end
  endtask

  initial begin
    Reset        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_bank  = '0;
    bus.wr_index = '0;
    bus.wr_rgb   = '0;
    bus.rd_valid = 1'b0;
    bus.rd_bank  = '0;
    bus.rd_index = '0;
`ifdef SPRITE_CLUT_FADE_EN
    bus.fade     = 4'd15;
`endif
    tick();
    tick();
    Reset = 1'b0;

    // Random traffic through the init phase must be ignored
    random_ticks(c_INIT_CYCLES + 4);
    drive_idle();
`ifdef SPRITE_CLUT_FADE_EN
    bus.fade = 4'd15;
`endif
    tick();
    tick();

    drive_rd(2, 2); tick();
    drive_rd(2, 0); tick();
    drive_idle();   tick(); tick();

    drive_wr(1, 6, 12'h3A5); drive_rd(1, 6); tick();
    drive_idle(); drive_rd(1, 6); tick();
    drive_rd(0, 6); tick();
    drive_idle(); tick(); tick();

    for (int i = 0; i < 16; i++) begin
      drive_rd(3, i);
      tick();
    end
    drive_idle(); tick(); tick();

`ifdef SPRITE_CLUT_FADE_EN
    bus.fade = 4'd7;  drive_rd(0, 6); tick();
    bus.fade = 4'd15; drive_rd(0, 6); tick();
    drive_idle(); tick(); tick();
`endif

    random_ticks(400);

    // Reset with reads in flight; reads held through the rerun init
    drive_idle();
`ifdef SPRITE_CLUT_FADE_EN
    bus.fade = 4'd15;
`endif
    drive_wr(1, 6, 12'h3A5); tick();
    drive_idle(); drive_rd(1, 5); tick();
    drive_rd(1, 6); tick();
    Reset = 1'b1; tick();
    Reset = 1'b0;
    for (int k = 0; k < c_INIT_CYCLES + 4; k++) tick();
    drive_idle(); tick(); tick();

    random_ticks(200);
    drive_idle(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
